// File: rtl/data_memory_unit.sv
// data_memory_unit -- MEM-stage data memory responder for the RV32 pipeline.
//
// Accepts one load/store at a time, stalls the pipeline with BUSY_WAIT for
// LATENCY+1 cycles, then presents the extended load result on DATA_READED
// in the DONE cycle.
//
// Ports:
//   CLK          in   rising-edge clock
//   RESET        in   synchronous, active-high reset
//   MEM_READ     in   [3]=read request, [2:0]=funct3 (LB/LH/LW/LBU/LHU)
//   MEM_WRITE    in   [2]=write request, [1:0]=size (SB/SH/SW)
//   ADDRESS      in   byte address
//   WRITE_DATA   in   store data
//   DATA_READED  out  registered, extended load result
//   BUSY_WAIT    out  stall request (combinational)
//   MISALIGNED   out  current IDLE request is misaligned (combinational)
//
// Configuration macro: DMEM_CLEAR_ON_RESET_EN -- when defined, every memory
// word is zeroed on the reset edge; otherwise contents survive reset.

module data_memory_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  MEM_READ,
  input  logic [2:0]  MEM_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] DATA_READED,
  output logic        BUSY_WAIT,
  output logic        MISALIGNED
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     mem [DEPTH_WORDS];

  // Latched request
  logic            l_wr;
  logic [1:0]      l_size;   // 00 byte, 01 half, 1x word
  logic            l_uns;
  logic [AW-1:0]   l_idx;
  logic [1:0]      l_off;
  logic [31:0]     l_wdata;

  logic            req, mis_req, accept, fire;
  logic [1:0]      size;
  logic [31:0]     rd_word, wr_word, load_val;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  // Upper address bits are deliberately ignored (addresses wrap).
  logic unused_addr;
  assign unused_addr = ^ADDRESS[31:AW+2];

  // A write wins when both requests are present, so size comes from the
  // write field in that case. funct3[1:0]=11 falls into the word bucket.
  assign req     = MEM_READ[3] | MEM_WRITE[2];
  assign size    = MEM_WRITE[2] ? MEM_WRITE[1:0] : MEM_READ[1:0];
  assign mis_req = ((size == 2'b01) & ADDRESS[0]) | (size[1] & (|ADDRESS[1:0]));
  assign accept  = (state == IDLE) & req & ~mis_req;
  assign fire    = (state == ACCESS) && (cnt == '0);

  assign MISALIGNED = (state == IDLE) & req & mis_req;
  assign BUSY_WAIT  = ~RESET & (accept | (state == ACCESS));

  // Little-endian lane extraction and merge for the latched access
  assign rd_word = mem[l_idx];
  assign rd_byte = rd_word[{l_off, 3'b000} +: 8];
  assign rd_half = rd_word[{l_off[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rd_word;
    wr_word  = l_wdata;
    case (l_size)
      2'b00: begin
        load_val = l_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        wr_word  = rd_word;
        wr_word[{l_off, 3'b000} +: 8] = l_wdata[7:0];
      end
      2'b01: begin
        load_val = l_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        wr_word  = rd_word;
        wr_word[{l_off[1], 4'b0000} +: 16] = l_wdata[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      DATA_READED <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          l_wr    <= MEM_WRITE[2];
          l_size  <= size;
          l_uns   <= ~MEM_WRITE[2] & MEM_READ[2];
          l_idx   <= ADDRESS[AW+1:2];
          l_off   <= ADDRESS[1:0];
          l_wdata <= WRITE_DATA;
          cnt     <= CW'(LATENCY - 1);
          state   <= ACCESS;
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!l_wr) DATA_READED <= load_val;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset aborts an in-flight store: the write is gated by !RESET.
  always_ff @(posedge CLK) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (RESET) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (fire && l_wr) begin
      mem[l_idx] <= wr_word;
    end
`else
    if (!RESET && fire && l_wr) mem[l_idx] <= wr_word;
`endif
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: directed steps followed by
// random traffic, compared against a byte-array reference model.
module tb_data_memory_unit;
  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic        CLK = 0;
  logic        RESET;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] ADDRESS, WRITE_DATA;
  logic [31:0] DATA_READED;
  logic        BUSY_WAIT, MISALIGNED;

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .DATA_READED(DATA_READED),
    .BUSY_WAIT(BUSY_WAIT), .MISALIGNED(MISALIGNED));

  always #5 CLK = ~CLK;

  int          n_chk = 0, n_err = 0;
  logic [7:0]  mm [DEPTH*4];
  logic [31:0] last_rd, last_obs, saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access width in bytes, straight from the opcode tables
  function automatic int nbytes(logic [3:0] mr, logic [2:0] mw);
    if (mw[2]) return (mw[1:0] == 2'b00) ? 1 : (mw[1:0] == 2'b01) ? 2 : 4;
    case (mr[2:0])
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] mload(logic [2:0] f3, logic [31:0] a);
    int ba;
    ba = int'(a & 32'(DEPTH*4 - 1));
    case (f3)
      3'b000:  return {{24{mm[ba][7]}}, mm[ba]};
      3'b100:  return {24'h0, mm[ba]};
      3'b001:  return {{16{mm[ba+1][7]}}, mm[ba+1], mm[ba]};
      3'b101:  return {16'h0, mm[ba+1], mm[ba]};
      default: return {mm[ba+3], mm[ba+2], mm[ba+1], mm[ba]};
    endcase
  endfunction

  task automatic clear_inputs();
    MEM_READ = 0; MEM_WRITE = 0; ADDRESS = 0; WRITE_DATA = 0;
  endtask

  // One request, entered #1 after a posedge; returns #1 after the posedge
  // that ends DONE (or the misaligned cycle). Request held through DONE.
  task automatic op(input logic [3:0] mr, input logic [2:0] mw, input logic [31:0] a,
                    input logic [31:0] wd, input bit swap, input string tag);
    int n, nb, ba;
    bit rq, mis_e, wr;
    logic [31:0] exp_rd, rd;
    logic mis_o;
    rq = mr[3] | mw[2];
    wr = mw[2];
    n  = nbytes(mr, mw);
    mis_e  = rq && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
    exp_rd = (rq && !mis_e && !wr) ? mload(mr[2:0], a) : last_rd;
    MEM_READ = mr; MEM_WRITE = mw; ADDRESS = a; WRITE_DATA = wd;
    nb = 0;
    @(negedge CLK);
    mis_o = MISALIGNED;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge CLK);
      if (!BUSY_WAIT) break;
      nb++;
      @(posedge CLK); #1;
      if (swap) ADDRESS = a ^ 32'h0000_0ff0;
    end
    rd = DATA_READED;
    chk({tag, ":mis"}, 32'(mis_o), 32'(mis_e));
    chk({tag, ":busy_cycles"}, 32'(nb), (rq && !mis_e) ? 32'(LAT + 1) : 32'd0);
    chk({tag, ":data"}, rd, exp_rd);
    @(posedge CLK); #1;
    clear_inputs();
    if (rq && !mis_e && wr) begin
      ba = int'(a & 32'(DEPTH*4 - 1));
      for (int k = 0; k < n; k++) mm[ba+k] = wd[8*k +: 8];
    end
    last_rd  = exp_rd;
    last_obs = rd;
  endtask

  task automatic model_reset();
    last_rd = 0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < DEPTH*4; i++) mm[i] = 8'h00;
`endif
  endtask

  initial begin
    clear_inputs();
    // Reset with an aligned request present: BUSY_WAIT must stay low
    RESET = 1; MEM_READ = 4'b1010;
    @(negedge CLK); chk("rst_busy", 32'(BUSY_WAIT), 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK); chk("rst_data", DATA_READED, 32'd0);
    @(posedge CLK); #1;
    RESET = 0; clear_inputs(); model_reset();

    // Fill every word so later reads are defined
    for (int w = 0; w < DEPTH; w++) op(4'b0000, 3'b110, 32'(w*4), $urandom, 0, "fill");

    op(4'b0000, 3'b110, 32'h10, 32'hDEADBEEF, 0, "sw10");
    op(4'b1010, 3'b000, 32'h10, 32'h0, 0, "lw10");
    chk("lw10_val", last_obs, 32'hDEADBEEF);
    op(4'b1000, 3'b000, 32'h13, 32'h0, 0, "lb13");  chk("lb13_val", last_obs, 32'hFFFFFFDE);
    op(4'b1100, 3'b000, 32'h13, 32'h0, 0, "lbu13"); chk("lbu13_val", last_obs, 32'h000000DE);
    op(4'b1001, 3'b000, 32'h12, 32'h0, 0, "lh12");  chk("lh12_val", last_obs, 32'hFFFFDEAD);
    op(4'b1101, 3'b000, 32'h10, 32'h0, 0, "lhu10"); chk("lhu10_val", last_obs, 32'h0000BEEF);
    op(4'b0000, 3'b100, 32'h11, 32'hAAAAAA5A, 0, "sb11");
    op(4'b1010, 3'b000, 32'h10, 32'h0, 0, "lw10b"); chk("sb_merge", last_obs, 32'hDEAD5AEF);

    // Misaligned requests
    op(4'b1010, 3'b000, 32'h22, 32'h0, 0, "lw22mis");
    @(negedge CLK);
    chk("mis_hold_data", DATA_READED, 32'hDEAD5AEF);
    chk("mis_idle_busy", 32'(BUSY_WAIT), 32'd0);
    @(posedge CLK); #1;
    op(4'b1010, 3'b000, 32'h20, 32'h0, 0, "lw20pre"); saved = last_obs;
    op(4'b0000, 3'b101, 32'h21, 32'h0000FFFF, 0, "sh21mis");
    op(4'b1010, 3'b000, 32'h20, 32'h0, 0, "lw20post"); chk("sh_mis_nowrite", last_obs, saved);

    // Held request, address changed during ACCESS, wrapped address
    op(4'b1010, 3'b000, 32'h410, 32'h0, 1, "held410"); chk("wrap410", last_obs, 32'hDEAD5AEF);
    // Read+write together acts as write only
    op(4'b1010, 3'b110, 32'h30, 32'h12345678, 0, "rw30");
    op(4'b1010, 3'b000, 32'h30, 32'h0, 0, "lw30"); chk("rw30_val", last_obs, 32'h12345678);

    // Abort a store in its second ACCESS cycle
    op(4'b1010, 3'b000, 32'h40, 32'h0, 0, "lw40pre"); saved = last_obs;
    MEM_WRITE = 3'b110; ADDRESS = 32'h40; WRITE_DATA = 32'h1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1;
    @(negedge CLK); chk("abort_busy_in_rst", 32'(BUSY_WAIT), 32'd0);
    @(posedge CLK); #1;
    RESET = 0; clear_inputs(); model_reset();
    @(negedge CLK);
    chk("abort_idle_busy", 32'(BUSY_WAIT), 32'd0);
    chk("abort_data_rst", DATA_READED, 32'd0);
    @(posedge CLK); #1;
    op(4'b1010, 3'b000, 32'h40, 32'h0, 0, "lw40post");
`ifdef DMEM_CLEAR_ON_RESET_EN
    chk("abort_40", last_obs, 32'h0);
    op(4'b1010, 3'b000, 32'h10, 32'h0, 0, "lw10rst"); chk("persist10", last_obs, 32'h0);
`else
    chk("abort_40", last_obs, saved);
    op(4'b1010, 3'b000, 32'h10, 32'h0, 0, "lw10rst"); chk("persist10", last_obs, 32'hDEAD5AEF);
`endif

    // Random traffic against the model
    for (int k = 0; k < 120; k++) begin
      logic [3:0]  mr;
      logic [2:0]  mw;
      logic [31:0] a;
      mr = 4'($urandom);
      mw = 3'($urandom);
      if (!mr[3] && !mw[2]) mr[3] = 1'b1;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      op(mr, mw, a, $urandom, bit'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
